// File: rtl/dx_stage_latch.sv
// Decode/execute pipeline register with load-use / RAW stall, branch flush and mul/div hold.
// Optional feature: define BYPASS_EN to stall only on load-use hazards.
module dx_stage_latch #(
  parameter int MD_LATENCY = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FD_ir,
  input  logic [31:0] FD_pc,
  input  logic [31:0] FD_a,
  input  logic [31:0] FD_b,
  input  logic [31:0] XM_ir,
  input  logic [31:0] MW_ir,
  input  logic        branch_flush,
  output logic [31:0] DX_ir,
  output logic [31:0] DX_pc,
  output logic [31:0] DX_a,
  output logic [31:0] DX_b,
  output logic        stall,
  output logic        dx_hold,
  output logic        md_start
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [5:0] CNT_INIT = 6'(MD_LATENCY - 2);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t     state;
  logic [5:0] cnt;
  logic       hazard;
  logic       load_use;

  // {valid, register} of the second source operand
  function automatic logic [5:0] src_b(input logic [31:0] ir);
    case (ir[31:27])
      OP_SW, OP_BNE, OP_BLT, OP_JR: src_b = {1'b1, ir[26:22]};
      OP_RTYPE:                     src_b = {1'b1, ir[16:12]};
      default:                      src_b = 6'd0;
    endcase
  endfunction

  // Destination register; 0 doubles as "none" since r0 never hazards
  function automatic logic [4:0] dest(input logic [31:0] ir);
    case (ir[31:27])
      OP_RTYPE, OP_ADDI, OP_LW: dest = ir[26:22];
      OP_JAL:                   dest = 5'd31;
      OP_SETX:                  dest = 5'd30;
      default:                  dest = 5'd0;
    endcase
  endfunction

  function automatic logic reads(input logic [31:0] ir, input logic [4:0] d);
    logic [5:0] b;
    b = src_b(ir);
    reads = (d != 5'd0) && ((ir[21:17] == d) || (b[5] && b[4:0] == d));
  endfunction

  function automatic logic is_md(input logic [31:0] ir);
    is_md = (ir[31:27] == OP_RTYPE) && (ir[6:2] == 5'b00110 || ir[6:2] == 5'b00111);
  endfunction

  assign load_use = (DX_ir[31:27] == OP_LW) && reads(FD_ir, DX_ir[26:22]);

`ifdef BYPASS_EN
  logic unused_bits;
  assign unused_bits = ^{FD_ir[11:7], FD_ir[1:0], XM_ir, MW_ir};
  assign hazard = load_use;
`else
  logic unused_bits;
  assign unused_bits = ^{FD_ir[11:7], FD_ir[1:0], XM_ir[21:0], MW_ir[21:0]};
  // A mul/div still in DX has already been waited out by the hold
  assign hazard = load_use
               || (!is_md(DX_ir) && reads(FD_ir, dest(DX_ir)))
               || reads(FD_ir, dest(XM_ir))
               || reads(FD_ir, dest(MW_ir));
`endif

  assign stall   = !reset && !branch_flush && (state == MD_WAIT || hazard);
  assign dx_hold = !reset && !branch_flush && (state == MD_WAIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      DX_ir    <= '0;
      DX_pc    <= '0;
      DX_a     <= '0;
      DX_b     <= '0;
      state    <= RUN;
      cnt      <= '0;
      md_start <= 1'b0;
    end else begin
      md_start <= 1'b0;
      if (branch_flush) begin
        DX_ir <= '0;
        DX_pc <= '0;
        DX_a  <= '0;
        DX_b  <= '0;
        state <= RUN;
        cnt   <= '0;
      end else if (state == MD_WAIT) begin
        if (cnt == 6'd0) state <= RUN;
        else             cnt   <= cnt - 6'd1;
      end else if (hazard) begin
        DX_ir <= '0;
        DX_pc <= '0;
        DX_a  <= '0;
        DX_b  <= '0;
      end else begin
        DX_ir <= FD_ir;
        DX_pc <= FD_pc;
        DX_a  <= FD_a;
        DX_b  <= FD_b;
        if (is_md(FD_ir)) begin
          state    <= MD_WAIT;
          cnt      <= CNT_INIT;
          md_start <= 1'b1;
        end
      end
    end
  end

endmodule
